// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: shared encodings, default latencies and the RAW compare helper.
//  Contents: md_state_t (IDLE/BUSY_MUL/BUSY_DIV), MULT_LAT_DEF, DIV_LAT_DEF, CNT_W_DEF, raw_hit().
package pipe_stall_ctrl_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY_MUL = 2'd1, BUSY_DIV = 2'd2} md_state_t;
   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;
   localparam int CNT_W_DEF    = 4;
   // A producer stalls a consumer only when its result is ready later than the consumer needs it.
   // Tuse=3 ("unused") can never be below a Tnew of 0..2, so it never stalls.
   function automatic logic raw_hit(input logic [4:0] x, input logic [1:0] tuse,
                                    input logic we, input logic [4:0] a3, input logic [1:0] tnew);
      return (x != 5'd0) && we && (a3 == x) && (tuse < tnew);
   endfunction
endpackage

// File: rtl/pipe_stall_ctrl_md_busy_fsm.sv
// md_busy_fsm: HI/LO multi-cycle busy sequencer (mult/div latency counter).
//  Ports: clk, reset (async, active-high), md_startE, md_divE in; md_busy, md_done out.
//  md_busy is high for exactly MULT_LAT/DIV_LAT cycles after the start edge; md_done marks the last one.
module md_busy_fsm
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic md_startE,
   input  logic md_divE,
   output logic md_busy,
   output logic md_done
);
   md_state_t        state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // A start while busy is ignored: the in-flight operation keeps its schedule.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      if (state == IDLE) begin
         state_n = md_startE ? (md_divE ? BUSY_DIV : BUSY_MUL) : IDLE;
         cnt_n   = md_startE ? (md_divE ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1)) : cnt;
      end else begin
         state_n = (cnt == '0) ? IDLE : state;
         cnt_n   = (cnt == '0) ? '0 : cnt - 1'b1;
      end
   end

   always_comb begin
      md_busy = state != IDLE;
      md_done = md_busy && (cnt == '0);
   end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush sequencer for the F/D, D/E, E/M, M/W pipeline registers.
//  Ports in : clk, reset (async, active-high), rsD, rtD, tuse_rsD, tuse_rtD, md_useD,
//             A3E, RegWriteE, tnewE, md_startE, md_divE, A3M, RegWriteM, tnewM.
//  Ports out: stall (hold PC and F/D), flush_DE (bubble into D/E), md_busy, md_done,
//             stall_cnt (only when STALL_STATS_EN is defined; saturating count of stall cycles).
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rsD,
   input  logic [4:0] rtD,
   input  logic [1:0] tuse_rsD,
   input  logic [1:0] tuse_rtD,
   input  logic       md_useD,
   input  logic [4:0] A3E,
   input  logic       RegWriteE,
   input  logic [1:0] tnewE,
   input  logic       md_startE,
   input  logic       md_divE,
   input  logic [4:0] A3M,
   input  logic       RegWriteM,
   input  logic [1:0] tnewM,
   output logic       stall,
   output logic       flush_DE,
   output logic       md_busy,
   output logic       md_done
`ifdef STALL_STATS_EN
   ,
   output logic [31:0] stall_cnt
`endif
);
   logic raw_stall, md_stall;

   md_busy_fsm #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_md (
      .clk       (clk),
      .reset     (reset),
      .md_startE (md_startE),
      .md_divE   (md_divE),
      .md_busy   (md_busy),
      .md_done   (md_done)
   );

   // md_startE counts as busy so a HI/LO reader right behind a mult/div waits from its first cycle.
   always_comb begin
      raw_stall = raw_hit(rsD, tuse_rsD, RegWriteE, A3E, tnewE) | raw_hit(rsD, tuse_rsD, RegWriteM, A3M, tnewM)
                | raw_hit(rtD, tuse_rtD, RegWriteE, A3E, tnewE) | raw_hit(rtD, tuse_rtD, RegWriteM, A3M, tnewM);
      md_stall  = md_useD & (md_busy | md_startE);
      stall     = raw_stall | md_stall;
      flush_DE  = stall;
   end

`ifdef STALL_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt <= '0;
      else if (stall && stall_cnt != 32'hFFFF_FFFF)
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif
endmodule
